// File: rtl/router_pkg.sv
// Shared router constants, output-port FSM state type and the one-hot helper.
package router_pkg;

    localparam int NPORTS = 5;
    localparam int IDX_W  = $clog2(NPORTS);

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_t;

    function automatic logic [NPORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NPORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/out_port_arb.sv
// One output port: eligibility decode, round-robin scan, packet lock FSM,
// owner/pointer state and the registered RTS toward the downstream router.
module out_port_arb
    import router_pkg::*;
#(
    parameter int OUT_IDX = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NPORTS-1:0]        req_i,
    input  logic [NPORTS*NPORTS-1:0] req_dst_i,
    input  logic [NPORTS-1:0]        req_tail_i,
    input  logic                     dcts_i,
    output logic [NPORTS-1:0]        grant_o,
    output logic [NPORTS-1:0]        xbar_sel_o,
    output logic                     rts_o
);

    out_state_t        state_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  ptr_q;
    logic              rts_q;

    logic [NPORTS-1:0] elig;
    logic              found;
    logic [IDX_W-1:0]  pick;
    logic              xfer;
    logic              owner_req;
    logic              owner_tail;

    // Only an exactly one-hot destination naming this output qualifies.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            elig[i] = req_i[i] &&
                      (req_dst_i[i*NPORTS +: NPORTS] == onehot(IDX_W'(OUT_IDX)));
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            int c;
            c = (int'(ptr_q) + k) % NPORTS;
            if (!found && elig[c]) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    assign owner_req  = req_i[owner_q];
    assign owner_tail = req_tail_i[owner_q];
    assign xfer       = (state_q == LOCKED) && rts_q && dcts_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NPORTS - 1);
            rts_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= LOCKED;
                        owner_q <= pick;
                        rts_q   <= 1'b1;
                    end else begin
                        rts_q   <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (xfer && owner_tail) begin
                        state_q <= IDLE;
                        ptr_q   <= owner_q;
                        rts_q   <= 1'b0;
                    end else begin
                        // RTS drops for one cycle after every accepted flit.
                        rts_q   <= owner_req && !xfer;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rts_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rts_o      = rts_q;
    assign xbar_sel_o = (state_q == LOCKED) ? onehot(owner_q) : '0;
    assign grant_o    = xfer ? onehot(owner_q) : '0;

endmodule

// File: rtl/switch_allocator.sv
// Per-output switch allocator: one arbiter per output port, grants OR-merged
// back onto the input ports.
module switch_allocator
    import router_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        Req,
    input  logic [NPORTS*NPORTS-1:0] Req_dst,
    input  logic [NPORTS-1:0]        Req_tail,
    input  logic [NPORTS-1:0]        DCTS,
    output logic [NPORTS-1:0]        Grant,
    output logic [NPORTS*NPORTS-1:0] Xbar_sel,
    output logic [NPORTS-1:0]        RTS
);

    logic [NPORTS-1:0] grant_vec [NPORTS];

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        out_port_arb #(
            .OUT_IDX (o)
        ) u_arb (
            .clk_i      (clk),
            .rst_i      (rst),
            .req_i      (Req),
            .req_dst_i  (Req_dst),
            .req_tail_i (Req_tail),
            .dcts_i     (DCTS[o]),
            .grant_o    (grant_vec[o]),
            .xbar_sel_o (Xbar_sel[o*NPORTS +: NPORTS]),
            .rts_o      (RTS[o])
        );
    end

    // Stable destinations per packet keep at most one output granting an input.
    always_comb begin
        Grant = '0;
        for (int o = 0; o < NPORTS; o++) begin
            Grant = Grant | grant_vec[o];
        end
    end

endmodule
